// File: rtl/sap1_pkg.sv
// SAP-1 controller constants: opcode map, FSM encoding, control-word bit indices
// and the combinational T-state/opcode decode shared by the controller.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int NUM_T = 6;

  // Which T-state is active lives in the ring counter; the FSM only tracks the mode.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int CW_PC_EN   = 0;
  localparam int CW_PC_INC  = 1;
  localparam int CW_MAR_LD  = 2;
  localparam int CW_RAM_EN  = 3;
  localparam int CW_IR_LD   = 4;
  localparam int CW_IR_EN   = 5;
  localparam int CW_A_LD    = 6;
  localparam int CW_A_EN    = 7;
  localparam int CW_B_LD    = 8;
  localparam int CW_OUT_LD  = 9;
  localparam int CW_ALU_EN  = 10;
  localparam int CW_ALU_SUB = 11;
  localparam int CW_W       = 12;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Bits are "asserted" flags; pin polarity is applied at the controller ports.
  function automatic ctrl_word_t decode_ctrl(input logic [NUM_T-1:0] t,
                                             input logic [3:0]       op);
    ctrl_word_t cw;
    cw = '0;
    if (t[0]) begin
      cw[CW_PC_EN]  = 1'b1;
      cw[CW_MAR_LD] = 1'b1;
    end
    if (t[1]) cw[CW_PC_INC] = 1'b1;
    if (t[2]) begin
      cw[CW_RAM_EN] = 1'b1;
      cw[CW_IR_LD]  = 1'b1;
    end
    if (t[3]) begin
      case (op)
        OP_LDA, OP_ADD, OP_SUB: begin
          cw[CW_IR_EN]  = 1'b1;
          cw[CW_MAR_LD] = 1'b1;
        end
        OP_OUT: begin
          cw[CW_A_EN]   = 1'b1;
          cw[CW_OUT_LD] = 1'b1;
        end
        default: ;
      endcase
    end
    if (t[4]) begin
      case (op)
        OP_LDA: begin
          cw[CW_RAM_EN] = 1'b1;
          cw[CW_A_LD]   = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          cw[CW_RAM_EN] = 1'b1;
          cw[CW_B_LD]   = 1'b1;
        end
        default: ;
      endcase
    end
    if (t[5]) begin
      if (op == OP_ADD || op == OP_SUB) begin
        cw[CW_ALU_EN] = 1'b1;
        cw[CW_A_LD]   = 1'b1;
      end
      if (op == OP_SUB) cw[CW_ALU_SUB] = 1'b1;
    end
    return cw;
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-stage one-hot T-state ring; an all-zero ring means "not executing".
// Enable from all-zero loads T1, otherwise rotates T6 back to T1; clear wins.
module sap1_ring_counter import sap1_pkg::*; (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [NUM_T-1:0] t_o
);

  logic [NUM_T-1:0] ring_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ring_q <= '0;
    end else if (clr_i) begin
      ring_q <= '0;
    end else if (en_i) begin
      ring_q <= (ring_q == '0) ? NUM_T'(1) : {ring_q[NUM_T-2:0], ring_q[NUM_T-1]};
    end
  end

  assign t_o = ring_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 sequencer: IDLE / RUN (T1..T6 via ring counter) / HALT, with the
// control word decoded combinationally from the active T-state and opcode.
module sap1_controller import sap1_pkg::*; (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             run_i,
  input  logic [3:0]       opcode_i,
  output logic             pc_en_o,
  output logic             pc_inc_o,
  output logic             mar_ld_n_o,
  output logic             ram_en_n_o,
  output logic             ir_ld_n_o,
  output logic             ir_en_n_o,
  output logic             a_ld_n_o,
  output logic             a_en_o,
  output logic             b_ld_n_o,
  output logic             out_ld_n_o,
  output logic             alu_en_o,
  output logic             alu_sub_o,
  output logic [NUM_T-1:0] tstate_o,
  output logic             halted_o
);

  state_e           state_q;
  logic             halted_q;
  logic [NUM_T-1:0] t;
  logic             ring_en;
  logic             ring_clr;
  logic             hlt_at_t4;
  logic             stop_at_t6;
  ctrl_word_t       cw;

  assign hlt_at_t4  = t[3] && (opcode_i == OP_HLT);
  assign stop_at_t6 = t[5] && !run_i;

  always_comb begin
    ring_en  = 1'b0;
    ring_clr = 1'b0;
    case (state_q)
      ST_IDLE: ring_en = run_i;
      ST_RUN: begin
        if (hlt_at_t4 || stop_at_t6) ring_clr = 1'b1;
        else                         ring_en  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (run_i) state_q <= ST_RUN;
        ST_RUN: begin
          if (hlt_at_t4) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (stop_at_t6) begin
            state_q <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  sap1_ring_counter u_ring (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en_i   (ring_en),
    .clr_i  (ring_clr),
    .t_o    (t)
  );

  // Ring is all-zero in IDLE/HALT, so the word is inactive there by construction.
  assign cw = decode_ctrl(t, opcode_i);

  assign pc_en_o    =  cw[CW_PC_EN];
  assign pc_inc_o   =  cw[CW_PC_INC];
  assign mar_ld_n_o = ~cw[CW_MAR_LD];
  assign ram_en_n_o = ~cw[CW_RAM_EN];
  assign ir_ld_n_o  = ~cw[CW_IR_LD];
  assign ir_en_n_o  = ~cw[CW_IR_EN];
  assign a_ld_n_o   = ~cw[CW_A_LD];
  assign a_en_o     =  cw[CW_A_EN];
  assign b_ld_n_o   = ~cw[CW_B_LD];
  assign out_ld_n_o = ~cw[CW_OUT_LD];
  assign alu_en_o   =  cw[CW_ALU_EN];
  assign alu_sub_o  =  cw[CW_ALU_SUB];
  assign tstate_o   = t;
  assign halted_o   = halted_q;

endmodule
